// File: rtl/cache_arb_pkg.sv
// Shared encodings for the cache AXI arbiter: FSM states and AXI field constants.
package cache_arb_pkg;

  typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrAddr, WrData, WrResp} wr_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past
// the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          grant_en,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      idx = IW'(cand);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// N-master to 1-slave AXI burst arbiter; read and write paths arbitrate independently and
// hold their grant for the whole burst.
module cache_axi_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_MST = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_MST*AW-1:0]   M_ARADDR,
  input  logic [NUM_MST*8-1:0]    M_ARLEN,
  input  logic [NUM_MST*2-1:0]    M_ARBURST,
  input  logic [NUM_MST-1:0]      M_ARVALID,
  output logic [NUM_MST-1:0]      M_ARREADY,
  output logic [DW-1:0]           M_RDATA,
  output logic [1:0]              M_RRESP,
  output logic                    M_RLAST,
  output logic [NUM_MST-1:0]      M_RVALID,
  input  logic [NUM_MST-1:0]      M_RREADY,
  input  logic [NUM_MST*AW-1:0]   M_AWADDR,
  input  logic [NUM_MST*8-1:0]    M_AWLEN,
  input  logic [NUM_MST*2-1:0]    M_AWBURST,
  input  logic [NUM_MST-1:0]      M_AWVALID,
  output logic [NUM_MST-1:0]      M_AWREADY,
  input  logic [NUM_MST*DW-1:0]   M_WDATA,
  input  logic [NUM_MST*DW/8-1:0] M_WSTRB,
  input  logic [NUM_MST-1:0]      M_WLAST,
  input  logic [NUM_MST-1:0]      M_WVALID,
  output logic [NUM_MST-1:0]      M_WREADY,
  output logic [1:0]              M_BRESP,
  output logic [NUM_MST-1:0]      M_BVALID,
  input  logic [NUM_MST-1:0]      M_BREADY,
  output logic [AW-1:0]           S_ARADDR,
  output logic [7:0]              S_ARLEN,
  output logic [1:0]              S_ARBURST,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  input  logic [DW-1:0]           S_RDATA,
  input  logic [1:0]              S_RRESP,
  input  logic                    S_RLAST,
  input  logic                    S_RVALID,
  output logic                    S_RREADY,
  output logic [AW-1:0]           S_AWADDR,
  output logic [7:0]              S_AWLEN,
  output logic [1:0]              S_AWBURST,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [DW-1:0]           S_WDATA,
  output logic [DW/8-1:0]         S_WSTRB,
  output logic                    S_WLAST,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY
);

  localparam int unsigned IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  rd_state_e     rd_state_q, rd_state_d;
  wr_state_e     wr_state_q, wr_state_d;
  logic [IW-1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
  logic [IW-1:0] rd_arb_idx, wr_arb_idx;
  logic          rd_arb_vld, wr_arb_vld, rd_take, wr_take;

  rr_arbiter #(.N(NUM_MST)) u_rd_arb (
    .clk       (CLK),
    .rst       (RST),
    .req       (M_ARVALID),
    .grant_en  (rd_take),
    .grant_idx (rd_arb_idx),
    .grant_vld (rd_arb_vld)
  );

  rr_arbiter #(.N(NUM_MST)) u_wr_arb (
    .clk       (CLK),
    .rst       (RST),
    .req       (M_AWVALID),
    .grant_en  (wr_take),
    .grant_idx (wr_arb_idx),
    .grant_vld (wr_arb_vld)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_state_q <= RdIdle;
      wr_state_q <= WrIdle;
      rd_gnt_q   <= '0;
      wr_gnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
    end
  end

  // The grant is only taken in idle, so the release cycle after a burst is a bubble.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_take    = 1'b0;
    unique case (rd_state_q)
      RdIdle: if (rd_arb_vld) begin
        rd_take    = 1'b1;
        rd_gnt_d   = rd_arb_idx;
        rd_state_d = RdAddr;
      end
      RdAddr: if (S_ARREADY) rd_state_d = RdData;
      RdData: if (S_RVALID && M_RREADY[rd_gnt_q] && S_RLAST) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_take    = 1'b0;
    unique case (wr_state_q)
      WrIdle: if (wr_arb_vld) begin
        wr_take    = 1'b1;
        wr_gnt_d   = wr_arb_idx;
        wr_state_d = WrAddr;
      end
      WrAddr: if (S_AWREADY) wr_state_d = WrData;
      WrData: if (M_WVALID[wr_gnt_q] && S_WREADY && M_WLAST[wr_gnt_q]) wr_state_d = WrResp;
      WrResp: if (S_BVALID && M_BREADY[wr_gnt_q]) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    S_ARVALID = 1'b0;
    S_ARADDR  = '0;
    S_ARLEN   = '0;
    S_ARBURST = '0;
    M_ARREADY = '0;
    S_RREADY  = 1'b0;
    M_RVALID  = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    M_RLAST   = 1'b0;
    if (rd_state_q == RdAddr) begin
      S_ARVALID           = 1'b1;
      S_ARADDR            = M_ARADDR[rd_gnt_q*AW +: AW];
      S_ARLEN             = M_ARLEN[rd_gnt_q*8 +: 8];
      S_ARBURST           = M_ARBURST[rd_gnt_q*2 +: 2];
      M_ARREADY[rd_gnt_q] = S_ARREADY;
    end
    if (rd_state_q == RdData) begin
      S_RREADY           = M_RREADY[rd_gnt_q];
      M_RVALID[rd_gnt_q] = S_RVALID;
      M_RDATA            = S_RDATA;
      M_RRESP            = S_RRESP;
      M_RLAST            = S_RLAST;
    end
  end

  // W is muxed only in WrData, so a master's early W beats stall until its AW is through.
  always_comb begin
    S_AWVALID = 1'b0;
    S_AWADDR  = '0;
    S_AWLEN   = '0;
    S_AWBURST = '0;
    M_AWREADY = '0;
    S_WVALID  = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WLAST   = 1'b0;
    M_WREADY  = '0;
    S_BREADY  = 1'b0;
    M_BVALID  = '0;
    M_BRESP   = '0;
    if (wr_state_q == WrAddr) begin
      S_AWVALID           = 1'b1;
      S_AWADDR            = M_AWADDR[wr_gnt_q*AW +: AW];
      S_AWLEN             = M_AWLEN[wr_gnt_q*8 +: 8];
      S_AWBURST           = M_AWBURST[wr_gnt_q*2 +: 2];
      M_AWREADY[wr_gnt_q] = S_AWREADY;
    end
    if (wr_state_q == WrData) begin
      S_WVALID           = M_WVALID[wr_gnt_q];
      S_WDATA            = M_WDATA[wr_gnt_q*DW +: DW];
      S_WSTRB            = M_WSTRB[wr_gnt_q*(DW/8) +: DW/8];
      S_WLAST            = M_WLAST[wr_gnt_q];
      M_WREADY[wr_gnt_q] = S_WREADY;
    end
    if (wr_state_q == WrResp) begin
      S_BREADY           = M_BREADY[wr_gnt_q];
      M_BVALID[wr_gnt_q] = S_BVALID;
      M_BRESP            = S_BRESP;
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter with four masters and a simple AXI slave model.
module tb_cache_axi_arbiter;
  import cache_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic CLK, RST;
  logic [N*AW-1:0]   M_ARADDR, M_AWADDR;
  logic [N*8-1:0]    M_ARLEN, M_AWLEN;
  logic [N*2-1:0]    M_ARBURST, M_AWBURST;
  logic [N-1:0]      M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_AWVALID, M_AWREADY;
  logic [N-1:0]      M_WLAST, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic [DW-1:0]     M_RDATA;
  logic [1:0]        M_RRESP, M_BRESP;
  logic              M_RLAST;
  logic [N*DW-1:0]   M_WDATA;
  logic [N*DW/8-1:0] M_WSTRB;
  logic [AW-1:0]     S_ARADDR, S_AWADDR;
  logic [7:0]        S_ARLEN, S_AWLEN;
  logic [1:0]        S_ARBURST, S_AWBURST, S_RRESP, S_BRESP;
  logic              S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
  logic              S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic [DW-1:0]     S_RDATA, S_WDATA;
  logic [DW/8-1:0]   S_WSTRB;

  cache_axi_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWBURST(M_AWBURST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ax_t;
  typedef struct packed {logic [1:0] mst; logic [63:0] data; logic last;} r_t;
  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last;} w_t;

  ax_t exp_ar[$];
  ax_t exp_aw[$];
  r_t  exp_r[$];
  w_t  exp_w[$];
  int  exp_b[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int r_cnt = 0;
  int ar_cyc = -1;
  int aw_cyc = -1;
  int last_rlast_cyc = -1;
  bit gap_chk = 0;
  bit wtog = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Slave read side: data beat i of a burst is {32'h0, addr} + i.
  logic [31:0] sr_addr;
  logic [7:0]  sr_len, sr_beat;
  logic        sr_busy;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_busy <= 1'b0; S_RVALID <= 1'b0; S_RLAST <= 1'b0; S_RDATA <= '0;
      sr_beat <= '0; sr_addr <= '0; sr_len <= '0;
    end else if (!sr_busy) begin
      if (S_ARVALID && S_ARREADY) begin
        sr_busy  <= 1'b1;
        sr_addr  <= S_ARADDR;
        sr_len   <= S_ARLEN;
        sr_beat  <= '0;
        S_RVALID <= 1'b1;
        S_RDATA  <= 64'(S_ARADDR);
        S_RLAST  <= (S_ARLEN == 8'd0);
      end
    end else if (S_RVALID && S_RREADY) begin
      if (S_RLAST) begin
        sr_busy  <= 1'b0;
        S_RVALID <= 1'b0;
        S_RLAST  <= 1'b0;
      end else begin
        sr_beat <= sr_beat + 8'd1;
        S_RDATA <= 64'(sr_addr) + 64'(sr_beat) + 64'd1;
        S_RLAST <= (sr_beat + 8'd1 == sr_len);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) S_WREADY <= 1'b0;
    else     S_WREADY <= wtog ? ~S_WREADY : 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) S_BVALID <= 1'b0;
    else if (S_WVALID && S_WREADY && S_WLAST) S_BVALID <= 1'b1;
    else if (S_BVALID && S_BREADY) S_BVALID <= 1'b0;
  end

  // Monitor: pops the scoreboard whenever a handshake is visible mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      if (S_ARVALID && S_ARREADY) begin
        if (gap_chk && last_rlast_cyc >= 0) chk("ar_gap", 64'(cyc - last_rlast_cyc), 64'd2);
        ar_cyc = cyc;
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(exp_ar.size()), 64'd1);
        else begin
          ax_t e;
          e = exp_ar.pop_front();
          chk("ar_addr", 64'(S_ARADDR), 64'(e.addr));
          chk("ar_len", 64'(S_ARLEN), 64'(e.len));
          chk("ar_burst", 64'(S_ARBURST), 64'(BURST_INCR));
        end
      end
      if (M_RVALID != '0) chk("r_onehot", 64'($onehot0(M_RVALID)), 64'd1);
      for (int m = 0; m < N; m++) begin
        if (M_RVALID[m] && M_RREADY[m]) begin
          r_cnt++;
          if (M_RLAST) last_rlast_cyc = cyc;
          if (exp_r.size() == 0) chk("r_unexpected", 64'(exp_r.size()), 64'd1);
          else begin
            r_t e;
            e = exp_r.pop_front();
            chk("r_mst", 64'(m), 64'(e.mst));
            chk("r_data", M_RDATA, e.data);
            chk("r_last", 64'(M_RLAST), 64'(e.last));
          end
        end
      end
      if (S_AWVALID && S_AWREADY) begin
        aw_cyc = cyc;
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(exp_aw.size()), 64'd1);
        else begin
          ax_t e;
          e = exp_aw.pop_front();
          chk("aw_addr", 64'(S_AWADDR), 64'(e.addr));
          chk("aw_len", 64'(S_AWLEN), 64'(e.len));
        end
      end
      if (S_WVALID && S_WREADY) begin
        if (exp_w.size() == 0) chk("w_unexpected", 64'(exp_w.size()), 64'd1);
        else begin
          w_t e;
          e = exp_w.pop_front();
          chk("w_data", S_WDATA, e.data);
          chk("w_strb", 64'(S_WSTRB), 64'(e.strb));
          chk("w_last", 64'(S_WLAST), 64'(e.last));
        end
      end
      for (int m = 0; m < N; m++) begin
        if (M_BVALID[m] && M_BREADY[m]) begin
          if (exp_b.size() == 0) chk("b_unexpected", 64'(exp_b.size()), 64'd1);
          else begin
            chk("b_mst", 64'(m), 64'(exp_b.pop_front()));
            chk("b_resp", 64'(M_BRESP), 64'(RESP_OKAY));
          end
        end
      end
    end
  end

  function automatic void push_rd(input int m, input logic [31:0] addr, input logic [7:0] len);
    exp_ar.push_back('{addr: addr, len: len});
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{mst: 2'(m), data: 64'(addr) + 64'(i), last: (i == int'(len))});
  endfunction

  function automatic void push_wr(input int m, input logic [31:0] addr, input int nb,
                                  input logic [63:0] base, input logic [7:0] strb);
    exp_aw.push_back('{addr: addr, len: 8'(nb - 1)});
    for (int i = 0; i < nb; i++)
      exp_w.push_back('{data: base + 64'(i), strb: strb, last: (i == nb - 1)});
    exp_b.push_back(m);
  endfunction

  task automatic rd_drive(input int m, input logic [31:0] addr, input logic [7:0] len);
    int k;
    M_ARADDR[m*AW +: AW] = addr;
    M_ARLEN[m*8 +: 8]    = len;
    M_ARBURST[m*2 +: 2]  = BURST_INCR;
    M_ARVALID[m]         = 1'b1;
    k = 0;
    do begin @(negedge CLK); k++; end while (!M_ARREADY[m] && k < 100);
    chk("ar_grant", 64'(M_ARREADY[m]), 64'd1);
    @(posedge CLK); #1;
    M_ARVALID[m] = 1'b0;
  endtask

  task automatic wr_drive(input int m, input logic [31:0] addr, input int nb,
                          input logic [63:0] base, input logic [7:0] strb, input bit early);
    int k;
    if (early) begin
      M_WDATA[m*DW +: DW] = base;
      M_WSTRB[m*8 +: 8]   = strb;
      M_WLAST[m]          = (nb == 1);
      M_WVALID[m]         = 1'b1;
      repeat (2) begin
        @(negedge CLK);
        chk("early_wready", 64'(M_WREADY[m]), 64'd0);
      end
      @(posedge CLK); #1;
    end
    M_AWADDR[m*AW +: AW] = addr;
    M_AWLEN[m*8 +: 8]    = 8'(nb - 1);
    M_AWBURST[m*2 +: 2]  = BURST_INCR;
    M_AWVALID[m]         = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (early) chk("early_wready_addr", 64'(M_WREADY[m]), 64'd0);
    end while (!M_AWREADY[m] && k < 100);
    chk("aw_grant", 64'(M_AWREADY[m]), 64'd1);
    @(posedge CLK); #1;
    M_AWVALID[m] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      M_WDATA[m*DW +: DW] = base + 64'(i);
      M_WSTRB[m*8 +: 8]   = strb;
      M_WLAST[m]          = (i == nb - 1);
      M_WVALID[m]         = 1'b1;
      k = 0;
      do begin @(negedge CLK); k++; end while (!M_WREADY[m] && k < 100);
      chk("w_accept", 64'(M_WREADY[m]), 64'd1);
      @(posedge CLK); #1;
    end
    M_WVALID[m] = 1'b0;
    M_WLAST[m]  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_ar.size() + exp_r.size() + exp_aw.size() + exp_w.size() + exp_b.size()) != 0
           && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("drain", 64'(exp_ar.size() + exp_r.size() + exp_aw.size() + exp_w.size() + exp_b.size()),
        64'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_s_valid_ready"}, 64'({S_ARVALID, S_AWVALID, S_WVALID, S_RREADY, S_BREADY}), 64'd0);
    chk({tag, "_m_arready"}, 64'(M_ARREADY), 64'd0);
    chk({tag, "_m_rvalid"}, 64'(M_RVALID), 64'd0);
    chk({tag, "_m_awready"}, 64'(M_AWREADY), 64'd0);
    chk({tag, "_m_wready"}, 64'(M_WREADY), 64'd0);
    chk({tag, "_m_bvalid"}, 64'(M_BVALID), 64'd0);
    chk({tag, "_rd_ptr"}, 64'(dut.u_rd_arb.ptr_q), 64'd0);
    chk({tag, "_wr_ptr"}, 64'(dut.u_wr_arb.ptr_q), 64'd0);
    chk({tag, "_rd_state"}, 64'(dut.rd_state_q), 64'(RdIdle));
    chk({tag, "_wr_state"}, 64'(dut.wr_state_q), 64'(WrIdle));
  endtask

  initial begin
    int base;
    int k;
    RST = 1'b1;
    M_ARADDR = '0; M_ARLEN = '0; M_ARBURST = '0; M_ARVALID = '0; M_RREADY = '1;
    M_AWADDR = '0; M_AWLEN = '0; M_AWBURST = '0; M_AWVALID = '0;
    M_WDATA = '0; M_WSTRB = '0; M_WLAST = '0; M_WVALID = '0; M_BREADY = '1;
    S_ARREADY = 1'b1; S_AWREADY = 1'b1; S_RRESP = RESP_OKAY; S_BRESP = RESP_OKAY;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_quiet("reset");
    chk("reset_araddr", 64'(S_ARADDR), 64'd0);
    chk("reset_arlen", 64'(S_ARLEN), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // All four masters request together; master 0 keeps requesting.
    gap_chk = 1'b1;
    last_rlast_cyc = -1;
    push_rd(0, 32'h1000_0000, 8'd1);
    push_rd(1, 32'h1100_0000, 8'd1);
    push_rd(2, 32'h1200_0000, 8'd1);
    push_rd(3, 32'h1300_0000, 8'd1);
    push_rd(0, 32'h1400_0000, 8'd1);
    fork
      begin
        rd_drive(0, 32'h1000_0000, 8'd1);
        rd_drive(0, 32'h1400_0000, 8'd1);
      end
      rd_drive(1, 32'h1100_0000, 8'd1);
      rd_drive(2, 32'h1200_0000, 8'd1);
      rd_drive(3, 32'h1300_0000, 8'd1);
    join
    drain();
    gap_chk = 1'b0;
    chk("contention_rd_ptr", 64'(dut.u_rd_arb.ptr_q), 64'd1);

    // Single read from master 1, one-cycle request latency.
    push_rd(1, 32'h8000_0040, 8'd7);
    fork
      rd_drive(1, 32'h8000_0040, 8'd7);
      begin
        @(negedge CLK);
        chk("lat_arvalid_t", 64'(S_ARVALID), 64'd0);
        @(negedge CLK);
        chk("lat_arvalid_t1", 64'(S_ARVALID), 64'd1);
        chk("lat_araddr_t1", 64'(S_ARADDR), 64'h8000_0040);
      end
    join
    drain();
    chk("single_rd_idle", 64'(dut.rd_state_q), 64'(RdIdle));
    chk("idle_araddr", 64'(S_ARADDR), 64'd0);
    chk("idle_rdata", M_RDATA, 64'd0);

    // Concurrent read (master 0) and 4-beat write (master 1).
    push_rd(0, 32'h2000_0000, 8'd3);
    push_wr(1, 32'h2100_0000, 4, 64'hCAFE_0000_0000_0010, 8'hFF);
    fork
      rd_drive(0, 32'h2000_0000, 8'd3);
      wr_drive(1, 32'h2100_0000, 4, 64'hCAFE_0000_0000_0010, 8'hFF, 1'b0);
    join
    drain();
    chk("ar_aw_overlap", 64'(ar_cyc), 64'(aw_cyc));
    chk("idle_wdata", S_WDATA, 64'd0);

    // Early W from master 0 with a toggling slave WREADY.
    wtog = 1'b1;
    push_wr(0, 32'h3000_0100, 4, 64'h0BAD_F00D_0000_0000, 8'h0F);
    wr_drive(0, 32'h3000_0100, 4, 64'h0BAD_F00D_0000_0000, 8'h0F, 1'b1);
    drain();
    wtog = 1'b0;

    // Response stall: master 2 holds BREADY low; master 3's AW must wait.
    M_BREADY[2] = 1'b0;
    push_wr(2, 32'h4000_0000, 2, 64'h2222_0000_0000_0000, 8'hF0);
    wr_drive(2, 32'h4000_0000, 2, 64'h2222_0000_0000_0000, 8'hF0, 1'b0);
    push_wr(3, 32'h4300_0000, 1, 64'h3333_0000_0000_0000, 8'hFF);
    fork
      wr_drive(3, 32'h4300_0000, 1, 64'h3333_0000_0000_0000, 8'hFF, 1'b0);
      begin
        repeat (5) begin
          @(negedge CLK);
          chk("stall_awvalid", 64'(S_AWVALID), 64'd0);
          chk("stall_bvalid", 64'(M_BVALID), 64'b0100);
          chk("stall_state", 64'(dut.wr_state_q), 64'(WrResp));
        end
        @(posedge CLK); #1;
        M_BREADY[2] = 1'b1;
      end
    join
    drain();

    // Reset during beat 3 of an 8-beat read, then a fresh request.
    push_rd(2, 32'h5000_0000, 8'd7);
    base = r_cnt;
    rd_drive(2, 32'h5000_0000, 8'd7);
    k = 0;
    while (r_cnt < base + 3 && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("rst_reached_beat3", 64'(r_cnt - base), 64'd3);
    RST = 1'b1;
    #1;
    chk_all_quiet("midrst");
    exp_r.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    push_rd(3, 32'h6000_0080, 8'd1);
    rd_drive(3, 32'h6000_0080, 8'd1);
    drain();
    chk("post_rst_rd_ptr", 64'(dut.u_rd_arb.ptr_q), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
